// File: rtl/frida_spi_pkg.sv
// Shared types and defaults for the FRIDA configuration-chain SPI initiator.
package frida_spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    SHIFT,
    TRAIL,
    DONE
  } state_t;

  localparam int FRIDA_CFG_NBITS  = 1280;
  localparam int FRIDA_CFG_WORD_W = 16;

endpackage

// File: rtl/frida_spi_clkdiv.sv
// SPI clock divider: CLK_DIV-cycle half periods, freezable, with rise/fall/half strobes.
module frida_spi_clkdiv
  import frida_spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_freeze,
  input  logic i_toggle,
  output logic o_sclk,
  output logic o_half,
  output logic o_rise,
  output logic o_fall
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_sclk;
  logic          w_half;

  assign w_half = !i_clr && !i_freeze && (r_cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (i_clr) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (!i_freeze) begin
      if (w_half) begin
        r_cnt <= '0;
        if (i_toggle) r_sclk <= ~r_sclk;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_sclk = r_sclk;
  assign o_half = w_half;
  assign o_rise = w_half && i_toggle && !r_sclk;
  assign o_fall = w_half && i_toggle && r_sclk;

endmodule

// File: rtl/frida_spi_cfg_master.sv
// Host-side SPI initiator streaming one NBITS frame into the FRIDA config chain.
// Define FRIDA_SPI_READBACK_EN to capture the previous chain contents from spi_sdo.
module frida_spi_cfg_master
  import frida_spi_pkg::*;
#(
  parameter int NBITS   = FRIDA_CFG_NBITS,
  parameter int WORD_W  = FRIDA_CFG_WORD_W,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_data,
  output logic              m_valid,
  output logic [WORD_W-1:0] m_data,
  output logic              spi_sclk,
  output logic              spi_sdi,
  output logic              spi_cs_b,
  input  logic              spi_sdo
);

  localparam int NWORDS = NBITS / WORD_W;
  localparam int BCW    = $clog2(NBITS);
  localparam int WBW    = $clog2(WORD_W);
  localparam int NWW    = $clog2(NWORDS + 1);

  state_t            r_state, w_state_nxt;
  logic [BCW-1:0]    r_bit_cnt;
  logic [WBW-1:0]    r_wbit;
  logic [NWW-1:0]    r_words;
  logic [WORD_W-1:0] r_hold, r_shift;
  logic              r_hold_vld, r_need, r_sdi;
  logic              w_half, w_rise, w_fall, w_sclk;
  logic              w_clr, w_freeze, w_toggle;
  logic              w_accept, w_load, w_last_bit, w_word_end;

  assign w_clr      = (r_state == IDLE) || (r_state == DONE);
  assign w_toggle   = (r_state == SHIFT);
  // Underflow: hold sclk low at the bit boundary until the next word lands.
  assign w_freeze   = (r_state == SHIFT) && r_need && !r_hold_vld;
  assign w_last_bit = (r_bit_cnt == BCW'(NBITS - 1));
  assign w_word_end = (r_wbit == WBW'(WORD_W - 1));
  assign w_accept   = s_valid && s_ready;
  assign w_load     = r_need && r_hold_vld && ((r_state == LEAD) || (r_state == SHIFT));
  assign s_ready    = busy && !r_hold_vld && (r_words < NWW'(NWORDS));

  frida_spi_clkdiv #(.CLK_DIV(CLK_DIV)) u_clkdiv (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_clr    (w_clr),
    .i_freeze (w_freeze),
    .i_toggle (w_toggle),
    .o_sclk   (w_sclk),
    .o_half   (w_half),
    .o_rise   (w_rise),
    .o_fall   (w_fall)
  );

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b1;
    done        = 1'b0;
    spi_cs_b    = 1'b0;
    unique case (r_state)
      IDLE: begin
        busy     = 1'b0;
        spi_cs_b = 1'b1;
        if (start) w_state_nxt = LEAD;
      end
      LEAD:  if (w_half) w_state_nxt = SHIFT;
      SHIFT: if (w_fall && w_last_bit) w_state_nxt = TRAIL;
      TRAIL: if (w_half) w_state_nxt = DONE;
      DONE: begin
        done        = 1'b1;
        spi_cs_b    = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        busy        = 1'b0;
        spi_cs_b    = 1'b1;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_bit_cnt  <= '0;
      r_wbit     <= '0;
      r_words    <= '0;
      r_hold_vld <= 1'b0;
      r_need     <= 1'b0;
      r_sdi      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE) begin
        if (start) begin
          r_bit_cnt  <= '0;
          r_wbit     <= '0;
          r_words    <= '0;
          r_need     <= 1'b1;
          r_hold_vld <= 1'b0;
        end
      end else begin
        if (w_accept) begin
          r_hold_vld <= 1'b1;
          r_words    <= r_words + 1'b1;
        end
        if (w_load) begin
          r_hold_vld <= 1'b0;
          r_need     <= 1'b0;
          r_wbit     <= '0;
          r_sdi      <= r_hold[WORD_W-1];
        end else if (w_fall) begin
          r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + 1'b1;
          if (w_word_end) begin
            r_need <= !w_last_bit;
          end else begin
            r_wbit <= r_wbit + 1'b1;
            r_sdi  <= r_shift[WORD_W-1];
          end
        end
        if (r_state == DONE) r_sdi <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_hold <= s_data;
    if (w_load) r_shift <= {r_hold[WORD_W-2:0], 1'b0};
    else if (w_fall && !w_word_end) r_shift <= {r_shift[WORD_W-2:0], 1'b0};
  end

  assign spi_sclk = w_sclk;
  assign spi_sdi  = r_sdi;

`ifdef FRIDA_SPI_READBACK_EN
  logic [WBW-1:0]    r_rbit;
  logic [WORD_W-1:0] r_cap, r_mdata;
  logic              r_mvalid;

  // spi_sdo is captured on the strobe that raises sclk, i.e. the chip's sampling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rbit   <= '0;
      r_mvalid <= 1'b0;
      r_mdata  <= '0;
    end else begin
      r_mvalid <= 1'b0;
      if ((r_state == IDLE) && start) begin
        r_rbit <= '0;
      end else if (w_rise) begin
        if (r_rbit == WBW'(WORD_W - 1)) begin
          r_rbit   <= '0;
          r_mvalid <= 1'b1;
          r_mdata  <= {r_cap[WORD_W-2:0], spi_sdo};
        end else begin
          r_rbit <= r_rbit + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_rise) r_cap <= {r_cap[WORD_W-2:0], spi_sdo};
  end

  assign m_valid = r_mvalid;
  assign m_data  = r_mdata;
`else
  logic w_rb_unused;
  assign w_rb_unused = spi_sdo ^ w_rise;
  assign m_valid     = 1'b0;
  assign m_data      = '0;
`endif

endmodule

// File: tb/tb_frida_spi_cfg_master.sv
// Scoreboard bench for frida_spi_cfg_master with a behavioural 1280-bit chip chain model.
module tb_frida_spi_cfg_master;

  localparam int NBITS   = 1280;
  localparam int WORD_W  = 16;
  localparam int CLK_DIV = 4;
  localparam int NWORDS  = NBITS / WORD_W;
  localparam int NOM_LEN = CLK_DIV * (2 * NBITS + 2);
`ifdef FRIDA_SPI_READBACK_EN
  localparam int RB_EXP = NWORDS;
`else
  localparam int RB_EXP = 0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              start, busy, done;
  logic              s_valid, s_ready;
  logic [WORD_W-1:0] s_data;
  logic              m_valid;
  logic [WORD_W-1:0] m_data;
  logic              spi_sclk, spi_sdi, spi_cs_b, spi_sdo;

  always #5 clk = ~clk;

  frida_spi_cfg_master #(.NBITS(NBITS), .WORD_W(WORD_W), .CLK_DIV(CLK_DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .spi_sclk (spi_sclk),
    .spi_sdi  (spi_sdi),
    .spi_cs_b (spi_cs_b),
    .spi_sdo  (spi_sdo)
  );

  // Chip-side chain: samples sdi on rising sclk, MSB drives sdo.
  logic [NBITS-1:0] chain;
  always @(posedge spi_sclk or posedge rst) begin
    if (rst) chain <= '0;
    else if (!spi_cs_b) chain <= {chain[NBITS-2:0], spi_sdi};
  end
  assign spi_sdo = chain[NBITS-1];

  typedef struct {
    logic [NBITS-1:0] data;
    int               min_len;
    bit               exact;
    logic             first_bit;
  } frame_t;

  frame_t            exp_frames[$];
  logic [WORD_W-1:0] exp_rb[$];
  logic [WORD_W-1:0] words[NWORDS];
  logic [NBITS-1:0]  prior;
  bit                abort;
  int                checks = 0;
  int                passes = 0;

  function automatic void chk(input string nm, input bit ok, input longint act, input longint req);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, req);
  endfunction

  // Monitor: frame measurements, done/readback scoreboard pops.
  int               cslen, rises, highrun, lowrun, maxlow, shape_err, sdi_err, rb_cnt;
  int               frames_done = 0;
  bit               first_seen;
  logic             first_bit, prev_cs, prev_sclk, prev_sdi;
  frame_t           mf;
  logic [WORD_W-1:0] mw;

  always @(negedge clk) begin
    if (rst) begin
      prev_cs   = 1'b1;
      prev_sclk = 1'b0;
      prev_sdi  = 1'b0;
    end else begin
      if (m_valid) begin
        rb_cnt++;
`ifdef FRIDA_SPI_READBACK_EN
        if (exp_rb.size() == 0) chk("rb_unexpected", 1'b0, m_data, 0);
        else begin
          mw = exp_rb.pop_front();
          chk("rb_word", m_data === mw, m_data, mw);
        end
`endif
      end
      if (prev_cs && !spi_cs_b) begin
        cslen = 0; rises = 0; highrun = 0; lowrun = 0; maxlow = 0;
        shape_err = 0; sdi_err = 0; rb_cnt = 0; first_seen = 1'b0;
      end
      if (!spi_cs_b) begin
        cslen++;
        if (spi_sclk) begin
          if (!prev_sclk) begin
            rises++;
            if (lowrun < CLK_DIV) shape_err++;
            if (lowrun > maxlow) maxlow = lowrun;
            if (!first_seen) begin
              first_bit  = spi_sdi;
              first_seen = 1'b1;
            end
          end
          highrun++;
          lowrun = 0;
          if (spi_sdi !== prev_sdi) sdi_err++;
        end else begin
          if (prev_sclk && highrun != CLK_DIV) shape_err++;
          highrun = 0;
          lowrun++;
        end
      end
      if (done) begin
        frames_done++;
        if (exp_frames.size() == 0) chk("unexpected_done", 1'b0, 1, 0);
        else begin
          mf = exp_frames.pop_front();
          if (mf.exact) chk("cs_len", cslen == mf.min_len, cslen, mf.min_len);
          else begin
            chk("cs_len_stall", cslen >= mf.min_len + 50, cslen, mf.min_len + 50);
            chk("stall_low_run", maxlow >= 50, maxlow, 50);
          end
          chk("done_after_cs_rise", !prev_cs && spi_cs_b, {prev_cs, spi_cs_b}, 2'b01);
          chk("chain", chain === mf.data, $countones(chain ^ mf.data), 0);
          chk("first_bit", first_bit === mf.first_bit, first_bit, mf.first_bit);
          chk("sclk_rises", rises == NBITS, rises, NBITS);
          chk("sclk_shape", shape_err == 0, shape_err, 0);
          chk("sdi_stable", sdi_err == 0, sdi_err, 0);
          chk("rb_count", rb_cnt == RB_EXP, rb_cnt, RB_EXP);
        end
      end
      prev_cs   = spi_cs_b;
      prev_sclk = spi_sclk;
      prev_sdi  = spi_sdi;
    end
  end

  task automatic send_word(input logic [WORD_W-1:0] w);
    int t;
    t = 0;
    @(negedge clk);
    s_data  = w;
    s_valid = 1'b1;
    while (!s_ready && !abort) begin
      @(negedge clk);
      t++;
      if (t > 30000) begin
        chk("send_timeout", 1'b0, t, 0);
        return;
      end
    end
  endtask

  task automatic run_frame(input int stall_idx, input int gap, input bit exact);
    frame_t f;
    f.data = '0;
    for (int i = 0; i < NWORDS; i++) f.data[NBITS-1-WORD_W*i -: WORD_W] = words[i];
    f.min_len   = NOM_LEN;
    f.exact     = exact;
    f.first_bit = words[0][WORD_W-1];
    exp_frames.push_back(f);
`ifdef FRIDA_SPI_READBACK_EN
    for (int i = 0; i < NWORDS; i++) exp_rb.push_back(prior[NBITS-1-WORD_W*i -: WORD_W]);
`endif
    prior = f.data;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < NWORDS; i++) begin
      if (abort) break;
      if (i == stall_idx) begin
        @(negedge clk);
        s_valid = 1'b0;
        repeat (gap - 1) @(negedge clk);
      end
      send_word(words[i]);
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int t;
    t = 0;
    while (frames_done < target && t < 25000) begin
      @(negedge clk);
      t++;
    end
    if (frames_done < target) chk("frame_timeout", 1'b0, frames_done, target);
  endtask

  int bz, tw, ta;

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    abort   = 1'b0;
    prior   = '0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {busy, done, s_ready, m_valid, spi_sclk, spi_sdi, spi_cs_b} === 7'b0000001,
        {busy, done, s_ready, m_valid, spi_sclk, spi_sdi, spi_cs_b}, 7'b0000001);
    chk("reset_mdata", m_data === '0, m_data, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Frame 1: 0x8001 then zeros.
    for (int i = 0; i < NWORDS; i++) words[i] = (i == 0) ? 16'h8001 : 16'h0000;
    run_frame(-1, 0, 1'b1);
    wait_done(1);

    // Frame 2: all ones; readback returns frame 1.
    for (int i = 0; i < NWORDS; i++) words[i] = 16'hFFFF;
    run_frame(-1, 0, 1'b1);
    wait_done(2);

    // Frame 3: underflow before word 10, plus start pulses mid-frame and in DONE.
    for (int i = 0; i < NWORDS; i++) words[i] = 16'(i * 16'h0101) ^ 16'h5A3C;
    fork
      run_frame(9, 330, 1'b0);
      begin
        repeat (600) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tw = 0;
        while (!done && tw < 30000) begin
          @(negedge clk);
          tw++;
        end
        if (!done) chk("done_wait", 1'b0, tw, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join
    wait_done(3);
    bz = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy) bz++;
    end
    chk("no_restart", bz == 0, bz, 0);

    // Frame 4: reset at bit 700.
    for (int i = 0; i < NWORDS; i++) words[i] = ~16'(i * 16'h0123);
    rises = 0;
    fork
      run_frame(-1, 0, 1'b1);
      begin
        ta = 0;
        while (rises < 700 && ta < 20000) begin
          @(negedge clk);
          ta++;
        end
        if (rises < 700) chk("abort_wait", 1'b0, rises, 700);
        rst = 1'b1;
        #1;
        chk("abort_cs_b", spi_cs_b === 1'b1, spi_cs_b, 1);
        chk("abort_sclk", spi_sclk === 1'b0, spi_sclk, 0);
        chk("abort_sdi", spi_sdi === 1'b0, spi_sdi, 0);
        chk("abort_busy", busy === 1'b0, busy, 0);
        abort = 1'b1;
        exp_frames.delete();
        exp_rb.delete();
        prior = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
      end
    join
    abort = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_after_rst", {busy, s_ready, spi_cs_b} === 3'b001, {busy, s_ready, spi_cs_b}, 3'b001);

    // Frame 5: full frame after the abort.
    for (int i = 0; i < NWORDS; i++) words[i] = 16'(i * 3 + 1) ^ 16'hC300;
    run_frame(-1, 0, 1'b1);
    wait_done(4);
    repeat (10) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
